tcp_tx_ctrl: RTL and testbench

- Transmit-side TCP control for the network processor; companion to the receive-side control that decodes incoming headers into rx messages.
- Accepts a transmit message request from the connection FSM and produces one TCP header field set for the header emitter.
- Owns the send sequence counter (snd_nxt).
- Retransmits SYN/SYN-ACK/FIN until the peer's matching ACK arrives or the retry budget runs out.

---
 rtl/tcp_tx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tcp_tx_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_ctrl.sv
// rtl/tcp_tx_ctrl.sv - transmit-side TCP header control with snd_nxt ownership and SYN/SYNACK/FIN retransmit
module tcp_tx_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_tx_msg,
    input  logic        i_tx_msg_valid,
    output logic        o_tx_msg_ack,
    input  logic [15:0] i_data_len,
    input  logic [31:0] i_iss,
    input  logic        i_iss_load,
    input  logic [31:0] i_rcv_nxt,
    input  logic [15:0] i_source_port,
    input  logic [15:0] i_dest_port,
    input  logic [15:0] i_window_size,
    input  logic [31:0] i_rx_ack_number,
    input  logic        i_rx_ack_valid,
    output logic [31:0] o_seq_number,
    output logic [31:0] o_ack_number,
    output logic [15:0] o_source_port,
    output logic [15:0] o_dest_port,
    output logic [7:0]  o_flags,
    output logic [15:0] o_window_size,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic [31:0] o_snd_nxt,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HDR      = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [2:0] MSG_SYN    = 3'd1;
    localparam logic [2:0] MSG_ACK    = 3'd2;
    localparam logic [2:0] MSG_SYNACK = 3'd3;
    localparam logic [2:0] MSG_FIN    = 3'd4;
    localparam logic [2:0] MSG_RST    = 3'd5;
    localparam logic [2:0] MSG_DATA   = 3'd6;

    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RETRY_MAX  = 32'(MAX_RETRIES);

    state_t      state_q;
    logic [31:0] snd_nxt_q;
    logic [31:0] timer_q;
    logic [31:0] retry_q;
    logic        first_q;
    logic        needs_ack_q;
    logic        ack_q;
    logic        timeout_q;
    logic        hdr_valid_q;
    logic [31:0] seq_q;
    logic [31:0] ack_num_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [7:0]  flags_q;
    logic [15:0] win_q;

    logic [7:0]  flags_d;
    logic [31:0] snd_nxt_d;
    logic [31:0] ack_num_d;
    logic        needs_ack_d;
    logic        hdr_msg_d;

    // Decode the request into its header flags and the snd_nxt it will leave behind.
    always_comb begin
        flags_d     = 8'h00;
        snd_nxt_d   = snd_nxt_q;
        ack_num_d   = i_rcv_nxt;
        needs_ack_d = 1'b0;
        hdr_msg_d   = 1'b1;
        case (i_tx_msg)
            MSG_SYN: begin
                flags_d     = 8'h02;
                snd_nxt_d   = snd_nxt_q + 32'd1;
                ack_num_d   = 32'd0;
                needs_ack_d = 1'b1;
            end
            MSG_ACK: flags_d = 8'h10;
            MSG_SYNACK: begin
                flags_d     = 8'h12;
                snd_nxt_d   = snd_nxt_q + 32'd1;
                needs_ack_d = 1'b1;
            end
            MSG_FIN: begin
                flags_d     = 8'h11;
                snd_nxt_d   = snd_nxt_q + 32'd1;
                needs_ack_d = 1'b1;
            end
            MSG_RST: flags_d = 8'h04;
            MSG_DATA: begin
                flags_d   = 8'h18;
                snd_nxt_d = snd_nxt_q + {16'd0, i_data_len};
            end
            default: hdr_msg_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            snd_nxt_q   <= 32'd0;
            timer_q     <= 32'd0;
            retry_q     <= 32'd0;
            first_q     <= 1'b0;
            needs_ack_q <= 1'b0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            seq_q       <= 32'd0;
            ack_num_q   <= 32'd0;
            src_q       <= 16'd0;
            dst_q       <= 16'd0;
            flags_q     <= 8'h00;
            win_q       <= 16'd0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ack_q guards against re-accepting the request in the cycle its ack is visible.
                    if (i_tx_msg_valid && !ack_q) begin
                        if (hdr_msg_d) begin
                            seq_q       <= snd_nxt_q;
                            ack_num_q   <= ack_num_d;
                            src_q       <= i_source_port;
                            dst_q       <= i_dest_port;
                            win_q       <= i_window_size;
                            flags_q     <= flags_d;
                            snd_nxt_q   <= snd_nxt_d;
                            needs_ack_q <= needs_ack_d;
                            retry_q     <= 32'd0;
                            first_q     <= 1'b1;
                            hdr_valid_q <= 1'b1;
                            state_q     <= S_HDR;
                        end else begin
                            ack_q <= 1'b1;
                        end
                    end
                    if (i_iss_load) begin
                        snd_nxt_q <= i_iss;
                    end
                end
                S_HDR: begin
                    if (i_hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        ack_q       <= first_q;
                        first_q     <= 1'b0;
                        timer_q     <= 32'd0;
                        state_q     <= needs_ack_q ? S_WAIT_ACK : S_IDLE;
                    end
                end
                S_WAIT_ACK: begin
                    timer_q <= timer_q + 32'd1;
                    if (i_rx_ack_valid && (i_rx_ack_number == snd_nxt_q)) begin
                        state_q <= S_IDLE;
                    end else if (timer_q == TIMER_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q     <= retry_q + 32'd1;
                            hdr_valid_q <= 1'b1;
                            state_q     <= S_HDR;
                        end else begin
                            timeout_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_tx_msg_ack  = ack_q;
    assign o_timeout     = timeout_q;
    assign o_hdr_valid   = hdr_valid_q;
    assign o_seq_number  = seq_q;
    assign o_ack_number  = ack_num_q;
    assign o_source_port = src_q;
    assign o_dest_port   = dst_q;
    assign o_flags       = flags_q;
    assign o_window_size = win_q;
    assign o_snd_nxt     = snd_nxt_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// tb/tb_tcp_tx_ctrl.sv - directed table-driven bench for tcp_tx_ctrl
module tb_tcp_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  tx_msg;
    logic        tx_msg_valid;
    logic        tx_msg_ack;
    logic [15:0] data_len;
    logic [31:0] iss;
    logic        iss_load;
    logic [31:0] rcv_nxt;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] window_size;
    logic [31:0] rx_ack_number;
    logic        rx_ack_valid;
    logic [31:0] seq_number;
    logic [31:0] ack_number;
    logic [15:0] src_o;
    logic [15:0] dst_o;
    logic [7:0]  flags;
    logic [15:0] win_o;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] snd_nxt;
    logic        busy;
    logic        timeout;

    always #5 clk = ~clk;

    tcp_tx_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tx_msg       (tx_msg),
        .i_tx_msg_valid (tx_msg_valid),
        .o_tx_msg_ack   (tx_msg_ack),
        .i_data_len     (data_len),
        .i_iss          (iss),
        .i_iss_load     (iss_load),
        .i_rcv_nxt      (rcv_nxt),
        .i_source_port  (source_port),
        .i_dest_port    (dest_port),
        .i_window_size  (window_size),
        .i_rx_ack_number(rx_ack_number),
        .i_rx_ack_valid (rx_ack_valid),
        .o_seq_number   (seq_number),
        .o_ack_number   (ack_number),
        .o_source_port  (src_o),
        .o_dest_port    (dst_o),
        .o_flags        (flags),
        .o_window_size  (win_o),
        .o_hdr_valid    (hdr_valid),
        .i_hdr_ready    (hdr_ready),
        .o_snd_nxt      (snd_nxt),
        .o_busy         (busy),
        .o_timeout      (timeout)
    );

    typedef struct {
        logic [2:0]  msg;
        logic [31:0] rcv;
        logic [15:0] len;
        logic [31:0] exp_seq;
        logic [31:0] exp_ack;
        logic [7:0]  exp_flags;
        logic [31:0] exp_snd;
        bit          waits;
    } vec_t;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hdr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (hdr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_iss(input logic [31:0] v);
        iss      = v;
        iss_load = 1'b1;
        step();
        iss_load = 1'b0;
        check("iss_load", snd_nxt, v);
    endtask

    task automatic do_vec(input vec_t v, input string tag);
        bit ok;
        rcv_nxt      = v.rcv;
        data_len     = v.len;
        tx_msg       = v.msg;
        hdr_ready    = 1'b1;
        tx_msg_valid = 1'b1;
        wait_hdr(ok);
        check($sformatf("%s_hdr_seen", tag), 32'(ok), 32'd1);
        check($sformatf("%s_seq", tag), seq_number, v.exp_seq);
        check($sformatf("%s_ack", tag), ack_number, v.exp_ack);
        check($sformatf("%s_flags", tag), 32'(flags), 32'(v.exp_flags));
        check($sformatf("%s_ports", tag), {src_o, dst_o}, 32'h1234_5678);
        check($sformatf("%s_window", tag), 32'(win_o), 32'h0000_4000);
        step();
        check($sformatf("%s_ack_pulse", tag), 32'(tx_msg_ack), 32'd1);
        tx_msg_valid = 1'b0;
        check($sformatf("%s_hdr_drop", tag), 32'(hdr_valid), 32'd0);
        check($sformatf("%s_snd_nxt", tag), snd_nxt, v.exp_snd);
        if (v.waits) begin
            check($sformatf("%s_busy_wait", tag), 32'(busy), 32'd1);
            rx_ack_number = v.exp_snd;
            rx_ack_valid  = 1'b1;
            step();
            rx_ack_valid  = 1'b0;
        end
        check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
        step();
        check($sformatf("%s_ack_single", tag), 32'(tx_msg_ack), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        bit bad;
        int hdrs, acks, tos, first_n, to_n;
        bit prev_v;
        logic [31:0] s_seq, s_ack;
        logic [7:0]  s_flags;
        vec_t wrap;

        vecs[0] = '{3'd1, 32'h0000_0055, 16'h0000, 32'h0000_1000, 32'h0000_0000, 8'h02, 32'h0000_1001, 1'b1};
        vecs[1] = '{3'd2, 32'hABCD_0001, 16'h0000, 32'h0000_1001, 32'hABCD_0001, 8'h10, 32'h0000_1001, 1'b0};
        vecs[2] = '{3'd6, 32'h0000_0077, 16'h0100, 32'h0000_1001, 32'h0000_0077, 8'h18, 32'h0000_1101, 1'b0};
        vecs[3] = '{3'd3, 32'h0000_0099, 16'h0000, 32'h0000_1101, 32'h0000_0099, 8'h12, 32'h0000_1102, 1'b1};
        vecs[4] = '{3'd5, 32'h0000_0005, 16'h0000, 32'h0000_1102, 32'h0000_0005, 8'h04, 32'h0000_1102, 1'b0};
        vecs[5] = '{3'd4, 32'h0000_0006, 16'h0000, 32'h0000_1102, 32'h0000_0006, 8'h11, 32'h0000_1103, 1'b1};

        rst_n         = 1'b0;
        tx_msg        = 3'd0;
        tx_msg_valid  = 1'b0;
        data_len      = 16'd0;
        iss           = 32'd0;
        iss_load      = 1'b0;
        rcv_nxt       = 32'd0;
        source_port   = 16'h1234;
        dest_port     = 16'h5678;
        window_size   = 16'h4000;
        rx_ack_number = 32'd0;
        rx_ack_valid  = 1'b0;
        hdr_ready     = 1'b1;

        step();
        step();
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_ack", 32'(tx_msg_ack), 32'd0);
        check("rst_snd_nxt", snd_nxt, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_seq", seq_number, 32'd0);
        rst_n = 1'b1;
        step();

        load_iss(32'h0000_1000);
        for (int i = 0; i < 6; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

        // ACK held off by a stalled emitter for five cycles.
        rcv_nxt      = 32'hABCD_0001;
        tx_msg       = 3'd2;
        hdr_ready    = 1'b0;
        tx_msg_valid = 1'b1;
        wait_hdr(ok);
        check("stall_hdr_seen", 32'(ok), 32'd1);
        s_seq = seq_number; s_ack = ack_number; s_flags = flags;
        check("stall_seq", s_seq, 32'h0000_1103);
        check("stall_acknum", s_ack, 32'hABCD_0001);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            if (!hdr_valid || seq_number !== s_seq || ack_number !== s_ack ||
                flags !== s_flags || tx_msg_ack) bad = 1'b1;
        end
        check("stall_stable", 32'(bad), 32'd0);
        hdr_ready = 1'b1;
        step();
        check("stall_ack_pulse", 32'(tx_msg_ack), 32'd1);
        tx_msg_valid = 1'b0;
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_snd_nxt", snd_nxt, 32'h0000_1103);
        step();
        check("stall_ack_single", 32'(tx_msg_ack), 32'd0);

        // NOP is acknowledged without a header.
        tx_msg       = 3'd0;
        tx_msg_valid = 1'b1;
        step();
        check("nop_ack", 32'(tx_msg_ack), 32'd1);
        check("nop_no_hdr", 32'(hdr_valid), 32'd0);
        tx_msg_valid = 1'b0;
        check("nop_busy", 32'(busy), 32'd0);
        step();

        // FIN with no peer ack: original plus two retransmits, then timeout.
        tx_msg = 3'd4; rcv_nxt = 32'd0; tx_msg_valid = 1'b1;
        hdrs = 0; acks = 0; tos = 0; first_n = -1; to_n = -1; prev_v = 1'b0; bad = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            step();
            if (hdr_valid && !prev_v) begin
                hdrs++;
                if (first_n < 0) first_n = n;
                if (seq_number !== 32'h0000_1103 || flags !== 8'h11) bad = 1'b1;
            end
            prev_v = hdr_valid;
            if (tx_msg_ack) begin
                acks++;
                tx_msg_valid = 1'b0;
            end
            if (timeout) begin
                tos++;
                to_n = n;
                break;
            end
        end
        check("fin_headers", 32'(hdrs), 32'd3);
        check("fin_fields", 32'(bad), 32'd0);
        check("fin_acks", 32'(acks), 32'd1);
        check("fin_timeout", 32'(tos), 32'd1);
        check("fin_timeout_cycle", 32'(to_n - first_n), 32'd51);
        check("fin_idle", 32'(busy), 32'd0);
        check("fin_snd_nxt", snd_nxt, 32'h0000_1104);
        step();
        check("fin_timeout_single", 32'(timeout), 32'd0);

        // SYN: stale ack is ignored, then a matching ack on the timeout cycle stops the retransmit.
        load_iss(32'h0000_1000);
        tx_msg = 3'd1; tx_msg_valid = 1'b1;
        wait_hdr(ok);
        check("syn2_hdr_seen", 32'(ok), 32'd1);
        check("syn2_seq", seq_number, 32'h0000_1000);
        step();
        check("syn2_ack_pulse", 32'(tx_msg_ack), 32'd1);
        tx_msg_valid  = 1'b0;
        rx_ack_number = 32'h0000_1000;
        rx_ack_valid  = 1'b1;
        step();
        rx_ack_valid  = 1'b0;
        check("syn2_wrong_ack_ignored", 32'(busy), 32'd1);
        wait_hdr(ok);
        check("syn2_retransmit", 32'(ok), 32'd1);
        check("syn2_retx_seq", seq_number, 32'h0000_1000);
        step();
        check("syn2_no_ack_on_retx", 32'(tx_msg_ack), 32'd0);
        for (int i = 0; i < 15; i++) step();
        rx_ack_number = 32'h0000_1001;
        rx_ack_valid  = 1'b1;
        step();
        rx_ack_valid  = 1'b0;
        check("syn2_ack_wins_idle", 32'(busy), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hdr_valid || timeout || busy) bad = 1'b1;
        end
        check("syn2_no_retx_after", 32'(bad), 32'd0);

        // DATA across the 32-bit wrap.
        load_iss(32'hFFFF_FFF0);
        wrap = '{3'd6, 32'h0000_0123, 16'h0020, 32'hFFFF_FFF0, 32'h0000_0123, 8'h18, 32'h0000_0010, 1'b0};
        do_vec(wrap, "wrap");

        // Reset while a header is waiting on the emitter.
        hdr_ready = 1'b0;
        tx_msg = 3'd1; tx_msg_valid = 1'b1;
        wait_hdr(ok);
        check("rstmid_hdr_seen", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_hdr_drop", 32'(hdr_valid), 32'd0);
        check("rstmid_snd_nxt", snd_nxt, 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        tx_msg_valid = 1'b0;
        hdr_ready    = 1'b1;
        step();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_msg_ack || hdr_valid) bad = 1'b1;
        end
        check("rstmid_no_ack", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
